// File: rtl/scanout_pkg.sv
// Shared types and default geometry for the line_scanout fetcher.
package scanout_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAITM = 3'd1,
        S_REQ   = 3'd2,
        S_WR    = 3'd3,
        S_LDONE = 3'd4,
        S_FDONE = 3'd5
    } state_t;

    localparam int WORD_W_DEF   = 128;
    localparam int PIX_W_DEF    = 8;
    localparam int H_ACTIVE_DEF = 640;
    localparam int PIX_PER_WORD = WORD_W_DEF / PIX_W_DEF;
    localparam int WPL          = H_ACTIVE_DEF / PIX_PER_WORD;
    localparam int LRAM_AW      = 1 + $clog2(WPL);

endpackage

// File: rtl/line_scanout_line_ram.sv
// Simple dual-port line RAM: synchronous write, synchronous registered read.
// Depth is a power of two so {bank, word} addresses index it directly.
module line_ram #(
    parameter int WORD_W = 128,
    parameter int AW     = 7
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [0:(1<<AW)-1];
    logic [WORD_W-1:0] rdata_r;

    // Write port
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clock) begin
        rdata_r <= mem_r[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/line_scanout.sv
// Double-buffered scanline fetcher: fetches line y+1 while streaming line y.
// Optional LINE_SCANOUT_UNDERRUN_FILL_EN: per-word valid flags, unwritten words show all-ones.
module line_scanout
    import scanout_pkg::*;
#(
    parameter int              WORD_W   = 128,
    parameter int              PIX_W    = 8,
    parameter int              H_ACTIVE = 640,
    parameter int              V_ACTIVE = 480,
    parameter int              H_TOTAL  = 800,
    parameter int              V_TOTAL  = 525,
    parameter int              ADDR_W   = 22,
    parameter logic [ADDR_W-1:0] BASE0  = 22'h200000,
    parameter logic [ADDR_W-1:0] BASE1  = 22'h100000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              display_en,
    input  logic              new_frame,
    input  logic              mem_wait,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  pix_index,
    output logic              busy,
    output logic              done,
    output logic              frame_sel,
    output logic              underrun
);

    localparam int PPW    = WORD_W / PIX_W;
    localparam int WORDS  = H_ACTIVE / PPW;
    localparam int WAW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int RAM_AW = 1 + WAW;
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

    state_t              state_r, state_next;
    logic [WAW-1:0]      word_r, word_next;
    logic [WORD_W-1:0]   wdata_r;
    logic [ADDR_W-1:0]   mem_addr_r, addr_s, base_s;
    logic                mem_rd_r, busy_r, done_r, frame_sel_r, underrun_r;
    logic [9:0]          fetch_line_s;
    logic                fetching_s, underrun_set_s, abort_s, start_s;
    logic [RAM_AW-1:0]   raddr_s;
    logic [WORD_W-1:0]   rdata_s;
    logic [LANE_W-1:0]   lane_r;
    logic                show_r;
    logic [PIX_W-1:0]    lane_pix_s;

    assign fetch_line_s   = (draw_y == 10'(V_TOTAL - 1)) ? 10'd0 : draw_y + 10'd1;
    assign start_s        = (draw_x == 10'd0) && (fetch_line_s < 10'(V_ACTIVE));
    assign fetching_s     = (state_r == S_WAITM) || (state_r == S_REQ) ||
                            (state_r == S_WR)    || (state_r == S_LDONE);
    assign underrun_set_s = (draw_x == 10'(H_TOTAL - 1)) &&
                            ((state_r == S_WAITM) || (state_r == S_REQ) || (state_r == S_WR));
    assign abort_s        = underrun_set_s || (new_frame && fetching_s);
    assign base_s         = frame_sel_r ? BASE1 : BASE0;
    assign addr_s         = base_s + ADDR_W'(fetch_line_s) * ADDR_W'(WORDS) + ADDR_W'(word_next);

    // Next-state and word counter
    always_comb begin
        state_next = state_r;
        word_next  = word_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) begin
                    state_next = S_WAITM;
                    word_next  = '0;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAITM: begin
                if (!mem_wait) state_next = S_REQ;
                else           state_next = S_WAITM;
            end
            S_REQ: begin
                if (mem_ack) state_next = S_WR;
                else         state_next = S_REQ;
            end
            S_WR: begin
                word_next = word_r + WAW'(1);
                if (word_r == WAW'(WORDS - 1)) state_next = S_LDONE;
                else                           state_next = S_REQ;
            end
            S_LDONE: begin
                if (fetch_line_s == 10'(V_ACTIVE - 1)) state_next = S_FDONE;
                else                                   state_next = S_IDLE;
            end
            S_FDONE: begin
                if (new_frame) state_next = S_IDLE;
                else           state_next = S_FDONE;
            end
            default: state_next = S_IDLE;
        endcase
        // Underrun or frame restart drops whatever was in flight
        if (abort_s) begin
            state_next = S_IDLE;
            word_next  = word_r;
        end else begin
            word_next  = word_next;
        end
    end

    // Control registers; outputs are decoded from the next state so they align with it
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= S_IDLE;
            word_r      <= '0;
            wdata_r     <= '0;
            mem_addr_r  <= '0;
            mem_rd_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            frame_sel_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            state_r  <= state_next;
            word_r   <= word_next;
            mem_rd_r <= (state_next == S_REQ);
            busy_r   <= (state_next == S_WAITM) || (state_next == S_REQ) ||
                        (state_next == S_WR)    || (state_next == S_LDONE);
            done_r   <= (state_next == S_FDONE);
            if ((state_r == S_REQ) && mem_ack) wdata_r <= mem_rdata;
            if (state_next == S_REQ)           mem_addr_r <= addr_s;
            if (new_frame)                     frame_sel_r <= ~frame_sel_r;
            if (underrun_set_s)                underrun_r <= 1'b1;
            else if (new_frame)                underrun_r <= 1'b0;
        end
    end

    assign raddr_s = {draw_y[0], WAW'(draw_x >> LANE_W)};

    line_ram #(.WORD_W(WORD_W), .AW(RAM_AW)) u_line_ram (
        .clock (clock),
        .we    (state_r == S_WR),
        .waddr ({fetch_line_s[0], word_r}),
        .wdata (wdata_r),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Pixel pipeline alignment with the RAM read latency
    always_ff @(posedge clock) begin
        if (reset) begin
            lane_r <= '0;
            show_r <= 1'b0;
        end else begin
            lane_r <= draw_x[LANE_W-1:0];
            show_r <= display_en && (draw_x < 10'(H_ACTIVE));
        end
    end

    assign lane_pix_s = rdata_s[lane_r*PIX_W +: PIX_W];

`ifdef LINE_SCANOUT_UNDERRUN_FILL_EN
    logic [(1<<WAW)-1:0] valid_r [2];
    logic                valid_q_r;

    // Valid flags: write bank cleared when a fetch starts, set per written word
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r[0] <= '0;
            valid_r[1] <= '0;
            valid_q_r  <= 1'b0;
        end else begin
            if ((state_r == S_IDLE) && (state_next == S_WAITM)) begin
                valid_r[fetch_line_s[0]] <= '0;
            end else if (state_r == S_WR) begin
                valid_r[fetch_line_s[0]][word_r] <= 1'b1;
            end
            valid_q_r <= valid_r[raddr_s[RAM_AW-1]][raddr_s[WAW-1:0]];
        end
    end

    // Pixel output with debug colour for words never written
    always_comb begin
        if (!show_r)         pix_index = '0;
        else if (!valid_q_r) pix_index = '1;
        else                 pix_index = lane_pix_s;
    end
`else
    // Pixel output
    always_comb begin
        if (show_r) pix_index = lane_pix_s;
        else        pix_index = '0;
    end
`endif

    assign mem_rd    = mem_rd_r;
    assign mem_addr  = mem_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign frame_sel = frame_sel_r;
    assign underrun  = underrun_r;

endmodule

// File: tb/tb_line_scanout.sv
// Scoreboard bench for line_scanout: request addresses and pixels are checked by monitors.
module tb_line_scanout;

    logic         clock = 1'b0;
    logic         reset;
    logic [9:0]   draw_x, draw_y;
    logic         display_en, new_frame, mem_wait;
    logic         mem_ack = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic         mem_rd;
    logic [21:0]  mem_addr;
    logic [7:0]   pix_index;
    logic         busy, done, frame_sel, underrun;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [21:0]  addr_q[$];
    logic [7:0]   pix_q[$];
    logic         ack_hold  = 1'b0;
    logic         pix_tag   = 1'b0;
    logic         pix_tag_d = 1'b0;
    logic         rd_prev   = 1'b0;

    line_scanout dut (
        .clock(clock), .reset(reset), .draw_x(draw_x), .draw_y(draw_y),
        .display_en(display_en), .new_frame(new_frame), .mem_wait(mem_wait),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .pix_index(pix_index), .busy(busy), .done(done), .frame_sel(frame_sel),
        .underrun(underrun)
    );

    always #5 clock = ~clock;

    // Byte j of the word at address a is {a[3:0], j}
    function automatic logic [127:0] mk(input logic [21:0] a);
        logic [127:0] d;
        for (int j = 0; j < 16; j++) d[j*8 +: 8] = {a[3:0], 4'(j)};
        return d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic pulse_nf;
        tick(); new_frame = 1'b1;
        tick(); new_frame = 1'b0;
    endtask

    task automatic drive_pix(input int x, input logic en, input logic [7:0] exp);
        tick();
        draw_x = 10'(x);
        display_en = en;
        pix_tag = 1'b1;
        pix_q.push_back(exp);
    endtask

    task automatic wait_quiet;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (i >= 2 && !busy && !mem_rd) break;
        end
    endtask

    // Memory responder: ack two cycles after a request is seen
    initial begin
        int acnt;
        acnt = 0;
        forever begin
            @(posedge clock);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_rd && !ack_hold) begin
                if (acnt == 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = mk(mem_addr);
                    acnt = 0;
                end else begin
                    acnt++;
                end
            end else begin
                acnt = 0;
            end
        end
    end

    // Request monitor
    always @(negedge clock) begin
        if (mem_rd && !rd_prev) begin
            if (addr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL req_unexpected: got addr %0h, required no request", mem_addr);
            end else begin
                chk("req_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            end
        end
        rd_prev <= mem_rd;
    end

    always @(posedge clock) pix_tag_d <= pix_tag;

    // Pixel monitor, one cycle after each driven column
    always @(negedge clock) begin
        if (pix_tag_d) begin
            if (pix_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pix_unexpected: got %0h, required no pixel", pix_index);
            end else begin
                chk("pix", 32'(pix_index), 32'(pix_q.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; draw_x = 10'd1; draw_y = 10'd0;
        display_en = 1'b0; new_frame = 1'b0; mem_wait = 1'b0;
        repeat (3) tick();
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_pix", 32'(pix_index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_frame_sel", 32'(frame_sel), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);

        // Start line 1 fetch from BASE0, then reset while in S_REQ
        addr_q.push_back(22'h200028);
        ack_hold = 1'b1; reset = 1'b0; draw_x = 10'd0;
        tick(); draw_x = 10'd1;
        tick();
        chk("mid_req_rd", 32'(mem_rd), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pix", 32'(pix_index), 32'd0);
        chk("mid_rst_frame_sel", 32'(frame_sel), 32'd0);
        reset = 1'b0; ack_hold = 1'b0;

        pulse_nf();
        chk("nf_frame_sel1", 32'(frame_sel), 32'd1);

        // Fetch line 10 from BASE1 into bank 0
        draw_y = 10'd9;
        for (int i = 0; i < 40; i++) addr_q.push_back(22'h100000 + 22'd400 + 22'(i));
        draw_x = 10'd0; tick(); draw_x = 10'd1;
        wait_quiet();
        chk("l10_reqs_left", 32'(addr_q.size()), 32'd0);
        chk("l10_busy", 32'(busy), 32'd0);
        chk("l10_done", 32'(done), 32'd0);

        // Scan out line 10; the line 11 fetch parks in S_WAITM
        mem_wait = 1'b1; draw_y = 10'd10;
        for (int x = 0; x < 16; x++) drive_pix(x, 1'b1, 8'(x));
        drive_pix(16, 1'b0, 8'h00);
        drive_pix(17, 1'b0, 8'h00);
        drive_pix(639, 1'b1, 8'h7F);
        drive_pix(640, 1'b1, 8'h00);
        tick(); pix_tag = 1'b0; display_en = 1'b0; draw_x = 10'd1;
        chk("parked_busy", 32'(busy), 32'd1);

        // Withhold ack until end of line
        ack_hold = 1'b1;
        addr_q.push_back(22'h1001B8);
        mem_wait = 1'b0;
        tick(); tick();
        chk("ur_req_rd", 32'(mem_rd), 32'd1);
        draw_x = 10'd799;
        tick();
        chk("ur_flag", 32'(underrun), 32'd1);
        chk("ur_rd_drop", 32'(mem_rd), 32'd0);
        chk("ur_busy", 32'(busy), 32'd0);
        draw_x = 10'd1; ack_hold = 1'b0;

        // Aborted line 11 sits in bank 1; park another fetch and abort it via new_frame
        mem_wait = 1'b1; draw_y = 10'd11;
`ifdef LINE_SCANOUT_UNDERRUN_FILL_EN
        drive_pix(0, 1'b1, 8'hFF);
        drive_pix(17, 1'b1, 8'hFF);
        tick(); pix_tag = 1'b0;
`else
        draw_x = 10'd0; tick();
`endif
        draw_x = 10'd1; display_en = 1'b0;
        chk("park2_busy", 32'(busy), 32'd1);
        chk("ur_sticky", 32'(underrun), 32'd1);
        pulse_nf();
        chk("nf_ur_clear", 32'(underrun), 32'd0);
        chk("nf_abort_busy", 32'(busy), 32'd0);
        chk("nf_frame_sel0", 32'(frame_sel), 32'd0);

        // Last line wraps to line 0 of BASE0
        mem_wait = 1'b0; draw_y = 10'd524;
        for (int i = 0; i < 40; i++) addr_q.push_back(22'h200000 + 22'(i));
        draw_x = 10'd0; tick(); draw_x = 10'd1;
        wait_quiet();
        chk("l0_reqs_left", 32'(addr_q.size()), 32'd0);
        chk("l0_busy", 32'(busy), 32'd0);

        // Line 480 is not visible: no fetch
        draw_y = 10'd479; draw_x = 10'd0; tick();
        chk("no_fetch_480", 32'(busy), 32'd0);
        draw_x = 10'd1;

        // Last visible line ends in S_FDONE
        draw_y = 10'd478;
        for (int i = 0; i < 40; i++) addr_q.push_back(22'h204AD8 + 22'(i));
        draw_x = 10'd0; tick(); draw_x = 10'd1;
        wait_quiet();
        chk("l479_reqs_left", 32'(addr_q.size()), 32'd0);
        chk("fdone_done", 32'(done), 32'd1);
        chk("fdone_busy", 32'(busy), 32'd0);
        pulse_nf();
        chk("nf_done_clear", 32'(done), 32'd0);
        chk("nf_frame_sel1b", 32'(frame_sel), 32'd1);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
